// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/stall/writeback controller between execute and the multdiv unit
module multdiv_issue_ctrl #(
    parameter int TIMEOUT       = 40,
    parameter int EXC_REG       = 30,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_is_mult,
    input  logic        in_is_div,
    input  logic [31:0] in_opA,
    input  logic [31:0] in_opB,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic            is_mult_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   tmo_cnt;
    logic            start;
    logic            capture;
    logic            normal_result;
    logic [31:0]     exc_data;

    assign start         = in_valid & (in_is_mult | in_is_div) & ~flush;
    assign normal_result = data_resultRDY & ~data_exception;
    assign exc_data      = is_mult_q ? 32'(MULT_EXC_CODE) : 32'(DIV_EXC_CODE);

    always_comb begin
        state_nxt = state;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        stall     = 1'b0;
        wb_valid  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ctrl_MULT = is_mult_q;
                ctrl_DIV  = ~is_mult_q;
                stall     = 1'b1;
                state_nxt = flush ? IDLE : BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                // flush outranks a simultaneous RDY: the result is dropped
                if (flush) begin
                    state_nxt = IDLE;
                end else if (data_resultRDY) begin
                    capture   = 1'b1;
                    state_nxt = (data_exception || rd_q != 5'd0) ? DONE : IDLE;
                end else if (tmo_cnt == CW'(TIMEOUT)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                wb_valid = 1'b1;
                stall    = 1'b1;
                if (wb_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_operandA <= 32'd0;
            data_operandB <= 32'd0;
            rd_q          <= 5'd0;
            is_mult_q     <= 1'b0;
        end else if (state == IDLE && start) begin
            data_operandA <= in_opA;
            data_operandB <= in_opB;
            rd_q          <= in_rd;
            is_mult_q     <= in_is_mult;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == BUSY && tmo_cnt != CW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Timeout and multdiv exceptions share the same status-register encoding
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_rd   <= 5'd0;
            wb_data <= 32'd0;
        end else if (capture) begin
            if (normal_result) begin
                wb_rd   <= rd_q;
                wb_data <= data_result;
            end else begin
                wb_rd   <= 5'(EXC_REG);
                wb_data <= exc_data;
            end
        end
    end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
- Pipeline-side controller that sits between the execute stage and the multdiv unit.
- Accepts a mult/div instruction, latches its operands and destination register, and issues a one-cycle ctrl_MULT/ctrl_DIV pulse.
- Holds operands stable, stalls the pipeline while the op is in flight, and waits for data_resultRDY.
- Presents the result to the writeback stage, with exception remapping to the status register, under a valid/ack handshake.

Parameters:
- TIMEOUT, 40: max BUSY cycles before the op is aborted as an exception.
- EXC_REG, 30: destination register used when an exception occurs.
- MULT_EXC_CODE, 4: value written to EXC_REG on multiply exception.
- DIV_EXC_CODE, 5: value written to EXC_REG on divide exception.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute-stage instruction valid.
- in_is_mult  in  1  instruction is mul.
- in_is_div  in  1  instruction is div.
- in_opA  in  32  operand A.
- in_opB  in  32  operand B.
- in_rd  in  5  destination register.
- flush  in  1  cancel in-flight op (branch mispredict).
- data_operandA  out  32  held operand A to multdiv.
- data_operandB  out  32  held operand B to multdiv.
- ctrl_MULT  out  1  one-cycle start pulse, multiply.
- ctrl_DIV  out  1  one-cycle start pulse, divide.
- data_result  in  32  from multdiv.
- data_exception  in  1  from multdiv.
- data_resultRDY  in  1  from multdiv.
- stall  out  1  freeze upstream pipeline.
- wb_valid  out  1  writeback request.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- wb_ack  in  1  writeback stage accepted request.

Behaviour:
- Reset (async) values:
  - state = IDLE.
  - All outputs 0, including held operands, ctrl pulses, stall, wb_valid, wb_rd, wb_data.
  - Timeout counter 0.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - Start condition: in_valid & (in_is_mult | in_is_div) & ~flush.
  - On start, at the clock edge: latch in_opA, in_opB, in_rd, and op type (mult if in_is_mult, else div); go to ISSUE.
  - If both in_is_mult and in_is_div are set, the op is treated as mult.
  - stall is combinationally high in the accepting cycle, so upstream freezes immediately.
- ISSUE (exactly 1 cycle):
  - ctrl_MULT or ctrl_DIV = 1 according to latched type; stall = 1; next state BUSY.
- BUSY:
  - stall = 1; ctrl pulses are 0; operands stay held; timeout counter increments each cycle.
  - data_resultRDY is sampled only in BUSY. The multdiv counter was reset by the ISSUE pulse, so a stale RDY from a prior op is never seen.
  - On RDY = 1, capture the result and go to DONE:
    - No exception: wb_rd = latched rd, wb_data = data_result.
    - Exception: wb_rd = EXC_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE.
  - On counter == TIMEOUT with no RDY: go to DONE with the exception encoding for the latched type.
- DONE:
  - wb_valid = 1; stall = 1; wb_rd and wb_data held stable until wb_ack.
  - On wb_ack: wb_valid = 0 next cycle, stall deasserts, go to IDLE.
  - A new op may be accepted in the cycle after returning to IDLE, never in the ack cycle.
- wb_rd == 0 with no exception: skip DONE and return directly to IDLE from BUSY; wb_valid is never asserted (writes to r0 are discarded).
- flush in ISSUE or BUSY:
  - Go to IDLE next cycle; any pending RDY is discarded; no wb_valid; stall drops the next cycle.
  - A pulse already emitted in ISSUE is not retracted; multdiv is restarted by the next issue.
- flush in DONE: ignored, because the op has already committed.
- Simultaneous RDY and flush in BUSY: flush wins; result is dropped.
- Reset mid-operation: immediate return to IDLE, all outputs 0, in-flight result lost.

Test Plan:
- Mult 7 x 6, rd = 5:
  - ctrl_MULT high exactly 1 cycle, the cycle after accept.
  - stall high from the accept cycle through the ack.
  - RDY -> wb_valid with wb_rd = 5, wb_data = 42.
  - wb_ack -> IDLE; stall low next cycle.
- Div 100 / 0, rd = 3:
  - data_exception = 1 -> wb_rd = 30, wb_data = 5.
  - Mult overflow 0x7FFFFFFF x 2 -> wb_rd = 30, wb_data = 4.
- Back-to-back mult then div with RDY left high from the first op:
  - The second op does not complete until a fresh RDY arrives in its BUSY state.
  - ctrl_DIV pulses once.
- flush during BUSY at cycle 10:
  - IDLE next cycle; no wb_valid ever; a later RDY pulse is ignored.
  - A following mult issues normally.
- RDY never asserted:
  - After TIMEOUT = 40 BUSY cycles -> wb_valid with wb_rd = 30, wb_data = 4 (mult).
  - Writeback on rd = 0 (no exception): no wb_valid, IDLE straight after RDY.
- Assert reset while in DONE with wb_ack = 0:
  - All outputs 0 immediately (asynchronously), state IDLE; the next start is accepted after reset release.
